// File: rtl/elevator_car_model_pkg.sv
// rtl/elevator_car_model_pkg.sv - shared direction codes, car states and field widths
package elevator_pkg;

    localparam logic [1:0] DIR_STOP    = 2'b00;
    localparam logic [1:0] DIR_UP      = 2'b01;
    localparam logic [1:0] DIR_DOWN    = 2'b10;
    localparam logic [1:0] DIR_ILLEGAL = 2'b11;

    localparam int FLOOR_W      = 3;
    localparam int NF_VALID_BIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } car_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_car_model_if.sv
// rtl/elevator_car_model_if.sv - controller/car command and status bundle
interface elevator_car_model_if;

    logic [1:0] DirectCurrent;
    logic       DoorReq;
    logic [3:0] NewFloor;
    logic       Door;
    logic [2:0] Position;
    logic       Moving;
    logic       Fault;

    // Controller side: issues commands, observes car status
    modport master (
        output DirectCurrent, DoorReq,
        input  NewFloor, Door, Position, Moving, Fault
    );

    // Car side: consumes commands, reports status
    modport slave (
        input  DirectCurrent, DoorReq,
        output NewFloor, Door, Position, Moving, Fault
    );

endinterface

// File: rtl/elevator_car_model_car_timer.sv
// rtl/elevator_car_model_car_timer.sv - loadable down-counter with zero flag
module car_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // Load wins over decrement; decrement saturates at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/elevator_car_model.sv
// rtl/elevator_car_model.sv - car motion and door sequencer driven by controller commands
module elevator_car_model
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 7,
    parameter int START_FLOOR   = 1,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_car_model_if.slave  bus
);

    // Counter needs at least one bit even when both durations are 1
    localparam int CW = max2(1, $clog2(max2(TRAVEL_CYCLES, DOOR_CYCLES)));

    localparam logic [CW-1:0]      TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0]      DOOR_LOAD   = CW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS);
    localparam logic [FLOOR_W-1:0] INIT_FLOOR  = FLOOR_W'(START_FLOOR);

    car_state_t         state;
    logic               dir_up;
    logic [FLOOR_W-1:0] position;
    logic [3:0]         new_floor;
    logic               door;
    logic               moving;
    logic               fault;

    logic               t_load;
    logic [CW-1:0]      t_load_value;
    logic               t_dec;
    logic [CW-1:0]      t_count;
    logic               t_zero;

    logic               up_ok;
    logic               down_ok;
    logic [FLOOR_W-1:0] next_position;

    assign up_ok         = (bus.DirectCurrent == DIR_UP)   && (position < TOP_FLOOR);
    assign down_ok       = (bus.DirectCurrent == DIR_DOWN) && (position > FLOOR_W'(1));
    assign next_position = dir_up ? position + 1'b1 : position - 1'b1;

    car_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (t_load),
        .load_value (t_load_value),
        .dec        (t_dec),
        .count      (t_count),
        .zero       (t_zero)
    );

    // Timer control mirrors the FSM decisions made on the same edge
    always_comb begin
        t_load       = 1'b0;
        t_load_value = '0;
        t_dec        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.DoorReq) begin
                    t_load       = 1'b1;
                    t_load_value = DOOR_LOAD;
                end else if (up_ok || down_ok) begin
                    t_load       = 1'b1;
                    t_load_value = TRAVEL_LOAD;
                end
            end
            MOVE: t_dec = !t_zero;
            DOOR: begin
                if (bus.DoorReq) begin
                    t_load       = 1'b1;
                    t_load_value = DOOR_LOAD;
                end else begin
                    t_dec = !t_zero;
                end
            end
            default: t_dec = 1'b0;
        endcase
    end

    // Car FSM: door has priority in IDLE, motion is uninterruptible, door hold-open by reload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir_up    <= 1'b0;
            position  <= INIT_FLOOR;
            new_floor <= 4'b0000;
            door      <= 1'b0;
            moving    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            new_floor <= 4'b0000;
            case (state)
                IDLE: begin
                    if (bus.DoorReq) begin
                        state <= DOOR;
                        door  <= 1'b1;
                    end else if (up_ok || down_ok) begin
                        state  <= MOVE;
                        dir_up <= up_ok;
                        moving <= 1'b1;
                    end else if (bus.DirectCurrent != DIR_STOP) begin
                        fault <= 1'b1;
                    end
                end
                MOVE: begin
                    if (t_zero) begin
                        state     <= IDLE;
                        position  <= next_position;
                        new_floor <= {1'b1, next_position};
                        moving    <= 1'b0;
                    end
                end
                DOOR: begin
                    if (!bus.DoorReq && t_zero) begin
                        state <= IDLE;
                        door  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.NewFloor = new_floor;
    assign bus.Door     = door;
    assign bus.Position = position;
    assign bus.Moving   = moving;
    assign bus.Fault    = fault;

endmodule

// File: tb/tb_elevator_car_model.sv
// tb/tb_elevator_car_model.sv - directed self-checking bench for elevator_car_model
module tb_elevator_car_model;
    import elevator_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    elevator_car_model_if bus();

    elevator_car_model #(
        .FLOORS        (7),
        .START_FLOOR   (1),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.DirectCurrent = DIR_STOP;
        bus.DoorReq       = 1'b0;
        #12;
        chk("rst_pos",   32'(bus.Position), 32'd1);
        chk("rst_nf",    32'(bus.NewFloor), 32'd0);
        chk("rst_door",  32'(bus.Door),     32'd0);
        chk("rst_mov",   32'(bus.Moving),   32'd0);
        chk("rst_fault", 32'(bus.Fault),    32'd0);
        step();
        reset = 1'b1;

        // Door request beats a simultaneous up command
        bus.DoorReq = 1'b1;
        bus.DirectCurrent = DIR_UP;
        step();
        chk("door_open", 32'(bus.Door),   32'd1);
        chk("door_nomv", 32'(bus.Moving), 32'd0);
        bus.DoorReq = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("door_hold%0d", i), 32'(bus.Door), 32'd1);
        end
        step();
        bus.DirectCurrent = DIR_STOP;
        chk("door_close", 32'(bus.Door),     32'd0);
        chk("door_pos",   32'(bus.Position), 32'd1);
        chk("door_nofl",  32'(bus.Fault),    32'd0);
        chk("door_nomv2", 32'(bus.Moving),   32'd0);

        // Hold-open pulse on the fourth edge of door-open
        bus.DoorReq = 1'b1;
        step();
        bus.DoorReq = 1'b0;
        step(); step(); step();
        bus.DoorReq = 1'b1;
        step();
        bus.DoorReq = 1'b0;
        step(); step();
        chk("hold_e6", 32'(bus.Door), 32'd1);
        step(); step(); step();
        chk("hold_e9", 32'(bus.Door), 32'd1);
        step();
        chk("hold_e10", 32'(bus.Door), 32'd0);

        // Up move with a down command arriving mid-travel
        bus.DirectCurrent = DIR_UP;
        step();
        chk("up_mov0", 32'(bus.Moving),   32'd1);
        chk("up_nf0",  32'(bus.NewFloor), 32'd0);
        step();
        bus.DirectCurrent = DIR_DOWN;
        step(); step();
        chk("up_mov3", 32'(bus.Moving),   32'd1);
        chk("up_pos3", 32'(bus.Position), 32'd1);
        step();
        chk("up_arr",  32'(bus.NewFloor), 32'hA);
        chk("up_pos",  32'(bus.Position), 32'd2);
        chk("up_mov4", 32'(bus.Moving),   32'd0);
        step();
        chk("rev_nf0",  32'(bus.NewFloor), 32'd0);
        chk("rev_mov",  32'(bus.Moving),   32'd1);
        bus.DirectCurrent = DIR_STOP;
        step(); step(); step();
        step();
        chk("rev_arr",  32'(bus.NewFloor), 32'h9);
        chk("rev_pos",  32'(bus.Position), 32'd1);
        step();
        chk("rev_nfclr", 32'(bus.NewFloor), 32'd0);
        chk("no_fault",  32'(bus.Fault),    32'd0);

        // Down at the bottom floor is a fault and it sticks
        bus.DirectCurrent = DIR_DOWN;
        step();
        chk("bot_fault", 32'(bus.Fault),    32'd1);
        chk("bot_mov",   32'(bus.Moving),   32'd0);
        chk("bot_pos",   32'(bus.Position), 32'd1);
        bus.DirectCurrent = DIR_STOP;
        step(); step();
        chk("bot_sticky", 32'(bus.Fault), 32'd1);

        // Illegal code sets the fault from a clean reset
        reset = 1'b0;
        #1;
        chk("rst2_fault", 32'(bus.Fault), 32'd0);
        step();
        reset = 1'b1;
        bus.DirectCurrent = DIR_ILLEGAL;
        step();
        chk("ill_fault", 32'(bus.Fault),  32'd1);
        chk("ill_mov",   32'(bus.Moving), 32'd0);

        // Climb to the top floor, then up again must fault
        reset = 1'b0;
        bus.DirectCurrent = DIR_STOP;
        step();
        reset = 1'b1;
        for (int f = 2; f <= 7; f++) begin
            bus.DirectCurrent = DIR_UP;
            step();
            bus.DirectCurrent = DIR_STOP;
            step(); step(); step();
            step();
            chk($sformatf("climb_nf%0d", f), 32'(bus.NewFloor), 32'(8 + f));
        end
        chk("top_pos0", 32'(bus.Position), 32'd7);
        chk("top_nofl", 32'(bus.Fault),    32'd0);
        bus.DirectCurrent = DIR_UP;
        step();
        chk("top_fault", 32'(bus.Fault),    32'd1);
        chk("top_pos",   32'(bus.Position), 32'd7);
        chk("top_mov",   32'(bus.Moving),   32'd0);

        // Asynchronous reset in the middle of a down move
        bus.DirectCurrent = DIR_DOWN;
        step();
        bus.DirectCurrent = DIR_STOP;
        step();
        chk("pre_mov", 32'(bus.Moving), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_pos",   32'(bus.Position), 32'd1);
        chk("ar_mov",   32'(bus.Moving),   32'd0);
        chk("ar_nf",    32'(bus.NewFloor), 32'd0);
        chk("ar_door",  32'(bus.Door),     32'd0);
        chk("ar_fault", 32'(bus.Fault),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_car_model.md
Name: elevator_car_model

Overview:
- Cycle-accurate model of the 7-floor car mechanism, driven by the elevator controller's direction output.
- Consumes the controller's direction command and a door request.
- Produces the floor-arrival code (NewFloor) and door status (Door) that the controller consumes.
- Used as the plant in system simulation and as the motion/door sequencer on the FPGA demo board.

Parameters:
- FLOORS, 7, number of floors, numbered 1..FLOORS; max 7 (3-bit floor code).
- START_FLOOR, 1, floor loaded into Position at reset.
- TRAVEL_CYCLES, 16, clock cycles to travel one floor (>=1).
- DOOR_CYCLES, 32, clock cycles the door stays open per request (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- DirectCurrent  input  2  direction command: 00 stop, 01 up, 10 down, 11 illegal.
- DoorReq  input  1  level request to open or hold the door.
- NewFloor  output  4  bit3 = arrival strobe (one cycle); bits2:0 = arrived floor; 4'b0000 when no arrival.
- Door  output  1  1 = door open, 0 = closed.
- Position  output  3  current floor (1..FLOORS); updates on arrival.
- Moving  output  1  1 while the car is between floors.
- Fault  output  1  sticky; set on an illegal command; cleared only by reset.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (reset=0, any state, including mid-move or door open):
  - state=IDLE, Position=START_FLOOR, NewFloor=0, Door=0, Moving=0, Fault=0, counters=0.
  - Effective immediately; first normal edge is the first rising clk after reset goes high.
- FSM states: IDLE, MOVE, DOOR.
- All outputs are registered; counter width is clog2 of max(TRAVEL_CYCLES, DOOR_CYCLES).
- IDLE, evaluated each edge in priority order:
  1. DoorReq=1 -> DOOR; Door=1 from this edge; door counter = DOOR_CYCLES-1.
  2. DirectCurrent=01 and Position<FLOORS -> MOVE up.
  3. DirectCurrent=10 and Position>1 -> MOVE down.
  4. DirectCurrent=01 at Position=FLOORS, 10 at Position=1, or 11 -> stay IDLE; Fault set to 1.
  5. DirectCurrent=00 -> stay IDLE.
  - Entering MOVE: direction latched internally, Moving=1 from this edge, travel counter = TRAVEL_CYCLES-1.
- MOVE:
  - Counter decrements each edge.
  - DirectCurrent and DoorReq are ignored; the car cannot stop or reverse between floors.
  - Edge where counter==0: Position +/-1 per latched direction, NewFloor={1'b1, new Position}, Moving=0, -> IDLE.
  - NewFloor returns to 0 on the following edge; the strobe is exactly one cycle.
  - Latency: a command sampled at edge E0 produces the NewFloor strobe visible after edge E0+TRAVEL_CYCLES.
  - Next command is sampled no earlier than edge E0+TRAVEL_CYCLES+1.
- DOOR:
  - Counter decrements each edge.
  - DoorReq=1 at any edge reloads the counter to DOOR_CYCLES-1 (hold-open); no upper bound.
  - Edge where counter==0 and DoorReq=0: Door=0, -> IDLE.
  - Move commands in DOOR are ignored and do not set Fault.
- TRAVEL_CYCLES=1: MOVE lasts exactly one edge.
- DOOR_CYCLES=1: door open exactly one cycle unless held.
- Position never leaves 1..FLOORS by construction.

Decomposition:
- Shared package elevator_pkg:
  - Direction codes DIR_STOP=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10, DIR_ILLEGAL=2'b11.
  - Car state enum {IDLE, MOVE, DOOR}.
  - Floor code width 3; NewFloor valid-bit index 3.
- The controller must import the same direction codes.
- One natural sub-module: car_timer, a loadable down-counter with a zero flag, shared by MOVE and DOOR.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=6, START_FLOOR=1):
- Reset released, DirectCurrent=01 at edge 0 -> Moving=1 for 4 cycles; NewFloor=4'b1010 for exactly one cycle after edge 4; Position=2; then NewFloor=0.
- At floor 1, DirectCurrent=10 -> no motion, Fault=1 and stays 1; DirectCurrent=11 also sets Fault.
- DoorReq=1 and DirectCurrent=01 on the same edge in IDLE -> Door=1, no motion; Door falls after 6 cycles with DoorReq low; Position unchanged.
- DoorReq pulsed at cycle 4 of door-open -> Door stays 1 until 6 cycles after the pulse.
- Mid-move DirectCurrent switched 01->10 at cycle 2 -> arrival still at floor 2 at cycle 4; reversal only after IDLE is re-entered.
- Drive up repeatedly to floor 7, then DirectCurrent=01 -> Fault=1, Position=7. Assert reset low mid-move -> Position=1, Moving=0, NewFloor=0, Door=0 immediately without a clock edge.
